// File: rtl/sram_iface_ctrl.sv
// sram_iface_ctrl
// Single-port controller turning a one-word request into a sequenced strobe
// on an asynchronous SRAM (IDLE -> SETUP -> ACCESS x ACCESS_CYCLES -> DONE).
//
// Optional feature macro: SRAM_IFACE_TURNAROUND_EN
//   defined   : a TURN state (dead bus cycle, no io_done) sits between ACCESS and DONE
//   undefined : ACCESS goes straight to DONE
//
// Ports:
//   clk          in   system clock, rising edge
//   n_rst        in   asynchronous reset, active HIGH (historical name)
//   start        in   request, acted on at its rising edge while IDLE
//   writemode    in   1 = write, 0 = read (sampled with start)
//   i_address    in   request address (sampled with start)
//   i_w_data     in   request write data (sampled with start)
//   i_r_data     out  last read result, held until the next read completes
//   io_done      out  one-cycle completion pulse
//   read_enable  out  SRAM read strobe
//   write_enable out  SRAM write strobe
//   address      out  SRAM address, holds its last value in IDLE
//   w_data       out  SRAM write data, holds its last value in IDLE
//   r_data       in   SRAM read data, valid while read_enable = 1
module sram_iface_ctrl #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              writemode,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_w_data,
  output logic [DATA_W-1:0] i_r_data,
  output logic              io_done,
  output logic              read_enable,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] r_data
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    TURN   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int              CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_t             state_r;
  state_t             next_state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   next_cnt_s;
  logic               start_q_r;
  logic               wm_r;
  logic               accept_s;
  logic               capture_s;

  logic               read_enable_s;
  logic               write_enable_s;
  logic               io_done_s;
  logic [ADDR_W-1:0]  address_s;
  logic [DATA_W-1:0]  w_data_s;
  logic [DATA_W-1:0]  i_r_data_s;

  // State register: FSM state, access counter, start edge history, latched mode.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      start_q_r <= 1'b0;
      wm_r      <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= next_cnt_s;
      start_q_r <= start;
      if (accept_s) begin
        wm_r <= writemode;
      end else begin
        wm_r <= wm_r;
      end
    end
  end

  // Next-state logic; start edges outside IDLE are dropped, not queued.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !start_q_r) begin
          accept_s     = 1'b1;
          next_state_s = SETUP;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP: begin
        next_cnt_s   = '0;
        next_state_s = ACCESS;
      end
      ACCESS: begin
        if (cnt_r == CNT_LAST) begin
          next_cnt_s = '0;
          // Read data is sampled on the edge that closes the last strobe cycle.
          capture_s  = !wm_r;
`ifdef SRAM_IFACE_TURNAROUND_EN
          next_state_s = TURN;
`else
          next_state_s = DONE;
`endif
        end else begin
          next_cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          next_state_s = ACCESS;
        end
      end
      TURN: begin
        next_state_s = DONE;
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode: next values for the output registers, derived from the next state
  // so that strobes and io_done come straight from flops.
  always_comb begin
    read_enable_s  = 1'b0;
    write_enable_s = 1'b0;
    io_done_s      = 1'b0;
    address_s      = address;
    w_data_s       = w_data;
    i_r_data_s     = i_r_data;

    if (accept_s) begin
      address_s = i_address;
      w_data_s  = i_w_data;
    end else begin
      address_s = address;
      w_data_s  = w_data;
    end

    // Exactly one strobe can be high, selected by the latched mode.
    if (next_state_s == ACCESS) begin
      write_enable_s = wm_r;
      read_enable_s  = !wm_r;
    end else begin
      write_enable_s = 1'b0;
      read_enable_s  = 1'b0;
    end

    if (next_state_s == DONE) begin
      io_done_s = 1'b1;
    end else begin
      io_done_s = 1'b0;
    end

    if (capture_s) begin
      i_r_data_s = r_data;
    end else begin
      i_r_data_s = i_r_data;
    end
  end

  // Output registers; async reset drops the strobes without waiting for a clock.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      io_done      <= 1'b0;
      address      <= '0;
      w_data       <= '0;
      i_r_data     <= '0;
    end else begin
      read_enable  <= read_enable_s;
      write_enable <= write_enable_s;
      io_done      <= io_done_s;
      address      <= address_s;
      w_data       <= w_data_s;
      i_r_data     <= i_r_data_s;
    end
  end

endmodule

// File: tb/tb_sram_iface_ctrl.sv
// Directed testbench for sram_iface_ctrl with a small SRAM behavioural model.
// Unwritten SRAM words read as 0x10000000 | address[7:0].
module tb_sram_iface_ctrl;

  localparam int ACC = 2;
`ifdef SRAM_IFACE_TURNAROUND_EN
  localparam int LAT = 3 + ACC;
`else
  localparam int LAT = 2 + ACC;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic        writemode;
  logic [15:0] i_address;
  logic [31:0] i_w_data;
  logic [31:0] i_r_data;
  logic        io_done;
  logic        read_enable;
  logic        write_enable;
  logic [15:0] address;
  logic [31:0] w_data;
  logic [31:0] r_data;

  int n_cmp = 0;
  int n_err = 0;

  // per-operation observations
  int          op_we, op_re, op_both, op_done_cnt, op_done_cycle, op_bad;
  logic [31:0] op_rdata;

  // dead-bus-gap monitor
  logic gap_arm = 1'b0;
  int   gap_run, min_gap;
  logic gap_seen;

  // SRAM model
  logic [31:0] mem     [0:255];
  bit          written [0:255];

  sram_iface_ctrl #(.ADDR_W(16), .DATA_W(32), .ACCESS_CYCLES(ACC)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .writemode    (writemode),
    .i_address    (i_address),
    .i_w_data     (i_w_data),
    .i_r_data     (i_r_data),
    .io_done      (io_done),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .address      (address),
    .w_data       (w_data),
    .r_data       (r_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [7:0] a);
    if (written[a]) return mem[a];
    else            return 32'h1000_0000 | {24'h0, a};
  endfunction

  always @(posedge clk) begin
    if (write_enable) begin
      mem[address[7:0]]     <= w_data;
      written[address[7:0]] <= 1'b1;
    end
  end

  assign r_data = read_enable ? mem_rd(address[7:0]) : 32'hDEAD_BEEF;

  // Tracks the shortest run of cycles with both strobes low between two strobe windows.
  always @(negedge clk) begin
    if (!gap_arm) begin
      gap_run  = 0;
      gap_seen = 1'b0;
      min_gap  = 9999;
    end else if (write_enable || read_enable) begin
      if (gap_seen && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
      gap_run  = 0;
      gap_seen = 1'b1;
    end else begin
      gap_run = gap_run + 1;
    end
  end

  // Issue one request and observe `window` cycles (negedge k samples the cycle k after E0).
  task automatic run_op(input logic wm, input logic [15:0] addr, input logic [31:0] data,
                        input int hold, input int pulse_at, input int window);
    op_we = 0; op_re = 0; op_both = 0; op_done_cnt = 0; op_done_cycle = -1; op_bad = 0;
    op_rdata = 32'h0;
    @(negedge clk);
    start = 1'b1; writemode = wm; i_address = addr; i_w_data = data;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (write_enable) begin
        op_we++;
        if (address !== addr || w_data !== data) op_bad++;
      end
      if (read_enable) begin
        op_re++;
        if (address !== addr) op_bad++;
      end
      if (write_enable && read_enable) op_both++;
      if (io_done) begin
        op_done_cnt++;
        op_done_cycle = k;
        op_rdata      = i_r_data;
      end
      if (k == hold) start = 1'b0;
      if (k == pulse_at) start = 1'b1;
      if (k == pulse_at + 1) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1; start = 1'b0; writemode = 1'b0; i_address = 16'h0; i_w_data = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({io_done, read_enable, write_enable} !== 3'b000) begin
      n_err++; $display("FAIL reset_strobes: got %b want 000", {io_done, read_enable, write_enable});
    end
    n_cmp++;
    if (address !== 16'h0 || w_data !== 32'h0) begin
      n_err++; $display("FAIL reset_addr_data: got %h/%h want 0000/00000000", address, w_data);
    end
    n_cmp++;
    if (i_r_data !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h want 00000000", i_r_data);
    end
    n_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    run_op(1'b1, 16'h00FA, 32'h0000_00AB, 5, -10, 10);
    n_cmp++;
    if (op_we !== ACC) begin n_err++; $display("FAIL write_we_cycles: got %0d want %0d", op_we, ACC); end
    n_cmp++;
    if (op_re !== 0) begin n_err++; $display("FAIL write_re_cycles: got %0d want 0", op_re); end
    n_cmp++;
    if (op_bad !== 0) begin n_err++; $display("FAIL write_addr_data: got %0d bad cycles want 0", op_bad); end
    n_cmp++;
    if (op_done_cnt !== 1 || op_done_cycle !== LAT) begin
      n_err++; $display("FAIL write_done: got %0d pulses at %0d want 1 at %0d", op_done_cnt, op_done_cycle, LAT);
    end
    n_cmp++;
    if (mem_rd(8'hFA) !== 32'h0000_00AB) begin
      n_err++; $display("FAIL write_mem_fa: got %h want 000000ab", mem_rd(8'hFA));
    end
  endtask

  task automatic test_read();
    run_op(1'b0, 16'h0001, 32'h0, 1, -10, 8);
    n_cmp++;
    if (op_re !== ACC) begin n_err++; $display("FAIL read_re_cycles: got %0d want %0d", op_re, ACC); end
    n_cmp++;
    if (op_we !== 0) begin n_err++; $display("FAIL read_we_cycles: got %0d want 0", op_we); end
    n_cmp++;
    if (op_done_cnt !== 1 || op_done_cycle !== LAT || op_rdata !== 32'h1000_0001) begin
      n_err++; $display("FAIL read_result: got %0d pulses at %0d data %h want 1 at %0d data 10000001",
                        op_done_cnt, op_done_cycle, op_rdata, LAT);
    end
    n_cmp++;
    if (i_r_data !== 32'h1000_0001) begin
      n_err++; $display("FAIL read_hold: got %h want 10000001", i_r_data);
    end
  endtask

  task automatic test_write_read();
    run_op(1'b1, 16'h00FB, 32'h0000_00CD, 1, -10, 8);
    n_cmp++;
    if (i_r_data !== 32'h1000_0001) begin
      n_err++; $display("FAIL write_keeps_rdata: got %h want 10000001", i_r_data);
    end
    run_op(1'b0, 16'h00FA, 32'h0, 1, -10, 8);
    n_cmp++;
    if (op_rdata !== 32'h0000_00AB || op_done_cycle !== LAT) begin
      n_err++; $display("FAIL readback_fa: got %h at %0d want 000000ab at %0d", op_rdata, op_done_cycle, LAT);
    end
    n_cmp++;
    if (mem_rd(8'hFA) !== 32'h0000_00AB || mem_rd(8'hFB) !== 32'h0000_00CD) begin
      n_err++; $display("FAIL dump_fa_fb: got %h/%h want 000000ab/000000cd", mem_rd(8'hFA), mem_rd(8'hFB));
    end
  endtask

  task automatic test_reset_mid_access();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    start = 1'b1; writemode = 1'b1; i_address = 16'h0040; i_w_data = 32'h0000_005A;
    @(negedge clk);   // SETUP
    start = 1'b0;
    @(negedge clk);   // first ACCESS cycle
    n_cmp++;
    if (write_enable !== 1'b1) begin
      n_err++; $display("FAIL abort_pre_we: got %b want 1", write_enable);
    end
    n_rst = 1'b1;
    #1;
    n_cmp++;
    if (write_enable !== 1'b0 || read_enable !== 1'b0) begin
      n_err++; $display("FAIL abort_enables_drop: got we=%b re=%b want 0/0", write_enable, read_enable);
    end
    repeat (2) begin
      @(negedge clk);
      if (io_done) done_seen++;
    end
    n_rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (io_done) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
    n_cmp++;
    if (i_r_data !== 32'h0 || address !== 16'h0) begin
      n_err++; $display("FAIL abort_outputs: got rdata %h addr %h want 0/0", i_r_data, address);
    end
    run_op(1'b0, 16'h0001, 32'h0, 1, -10, 8);
    n_cmp++;
    if (op_done_cnt !== 1 || op_done_cycle !== LAT || op_rdata !== 32'h1000_0001) begin
      n_err++; $display("FAIL abort_then_read: got %0d pulses at %0d data %h want 1 at %0d data 10000001",
                        op_done_cnt, op_done_cycle, op_rdata, LAT);
    end
  endtask

  task automatic test_ignored_pulse();
    run_op(1'b1, 16'h0020, 32'h0000_0077, 1, 2, 12);
    n_cmp++;
    if (op_done_cnt !== 1 || op_we !== ACC) begin
      n_err++; $display("FAIL ignored_pulse: got %0d done %0d we cycles want 1 done %0d we cycles",
                        op_done_cnt, op_we, ACC);
    end
    n_cmp++;
    if (mem_rd(8'h20) !== 32'h0000_0077) begin
      n_err++; $display("FAIL ignored_pulse_mem: got %h want 00000077", mem_rd(8'h20));
    end
  endtask

  task automatic test_back_to_back();
    gap_arm = 1'b1;
    run_op(1'b1, 16'h0030, 32'h0000_0099, 1, -10, LAT);
    n_cmp++;
    if (op_done_cycle !== LAT || op_both !== 0) begin
      n_err++; $display("FAIL b2b_write: got done at %0d both %0d want %0d/0", op_done_cycle, op_both, LAT);
    end
    run_op(1'b0, 16'h0030, 32'h0, 1, -10, LAT + 1);
    n_cmp++;
    if (op_rdata !== 32'h0000_0099 || op_done_cycle !== LAT) begin
      n_err++; $display("FAIL b2b_read: got %h at %0d want 00000099 at %0d", op_rdata, op_done_cycle, LAT);
    end
    n_cmp++;
    if (min_gap !== LAT - 1 || min_gap < 2) begin
      n_err++; $display("FAIL b2b_dead_gap: got %0d want %0d", min_gap, LAT - 1);
    end
    gap_arm = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_write_read();
    test_reset_mid_access();
    test_ignored_pulse();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
